mc_controller: RTL and testbench

Multicycle main controller for the RISC-V core: a Moore FSM (Mealy only on the memory handshake) that sequences fetch, decode, address generation, memory access, execute and writeback across several cycles. Drives the select lines of the shared datapath resources: `ImmSrc` of the immediate generator, ALU operand muxes, ALU operation, result mux, memory address mux and register/PC/IR write enables. Supports lw, sw, R-type ALU, I-type ALU and beq, against a single unified memory with a ready handshake.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/mc_controller.sv | 162 ++++++++++++++++
 tb/tb_mc_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes and
// the select-line encodings seen by the immediate generator, ALU muxes and ALU.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_ILLEGAL  = 4'd10
   } mc_state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields to alu_control.
module mc_alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only selects sub for R-type; I-type addi reuses that bit as immediate
               3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller FSM (lw, sw, R/I ALU, beq) with a memory ready handshake.
// Define MC_CTRL_ILLEGAL_EN to trap unknown opcodes in an ILLEGAL state with an `illegal` output.
module mc_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] alu_control,
`ifdef MC_CTRL_ILLEGAL_EN
   output logic       illegal,
`endif
   output logic       instr_done
);

`ifdef MC_CTRL_ILLEGAL_EN
   localparam mc_state_e UNKNOWN_NEXT = S_ILLEGAL;
`else
   localparam mc_state_e UNKNOWN_NEXT = S_FETCH;
`endif

   mc_state_e  state_q, state_d;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               default:           state_d = UNKNOWN_NEXT;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore decode of state; only the handshake-qualified strobes look at mem_ready.
   always_comb begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      RegWrite   = 1'b0;
      ImmSrc     = IMM_I;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ResultSrc  = RES_ALUOUT;
      alu_op     = ALUOP_ADD;
      instr_done = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = mem_ready;
            pc_update = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = op[5] ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            MemWrite   = 1'b1;
            AdrSrc     = 1'b1;
            instr_done = mem_ready;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_I;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            ResultSrc  = RES_ALUOUT;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite = pc_update | (branch & zero);

`ifdef MC_CTRL_ILLEGAL_EN
   assign illegal = (state_q == S_ILLEGAL);
`endif

   mc_alu_decoder u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected output vectors queued with the stimulus.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done;
   logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] alu_control;
`ifdef MC_CTRL_ILLEGAL_EN
   logic       illegal;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .MemWrite    (MemWrite),
      .AdrSrc      (AdrSrc),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .RegWrite    (RegWrite),
      .ImmSrc      (ImmSrc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ResultSrc   (ResultSrc),
      .alu_control (alu_control),
`ifdef MC_CTRL_ILLEGAL_EN
      .illegal     (illegal),
`endif
      .instr_done  (instr_done)
   );

   logic [17:0] obs;
   assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, alu_control, instr_done};

   typedef struct {
      string       tag;
      logic        rdy;
      logic        z;
      logic [17:0] exp;
   } step_t;

   step_t sb_q[$];

   function automatic logic [17:0] ex(logic mreq, logic mw, logic adr, logic irw, logic pcw,
                                      logic rw, logic [1:0] imm, logic [1:0] sa, logic [1:0] sb,
                                      logic [1:0] rs, logic [2:0] alu, logic done);
      return {mreq, mw, adr, irw, pcw, rw, imm, sa, sb, rs, alu, done};
   endfunction

   task automatic chk(string tag, logic [17:0] o, logic [17:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push(string tag, logic rdy, logic z, logic [17:0] e);
      step_t s;
      s.tag = tag;
      s.rdy = rdy;
      s.z   = z;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   // One queue entry per clock cycle: drive at negedge, sample 1ns later.
   task automatic drain();
      step_t s;
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         @(negedge clk);
         mem_ready = s.rdy;
         zero      = s.z;
         #1;
         chk(s.tag, obs, s.exp);
      end
   endtask

   task automatic push_fetch(string tag, int waits);
      for (int i = 0; i < waits; i++)
         push({tag, "_fetch_wait"}, 1'b0, 1'b0, ex(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
      push({tag, "_fetch"}, 1'b1, 1'b0, ex(1,0,0,1,1,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
      push({tag, "_decode"}, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'b10,2'b01,2'b01,2'b00,3'b000,0));
   endtask

   task automatic do_reset();
      #2;
      reset     = 1'b1;
      mem_ready = 1'b0;
      #1;
      chk("reset_outputs", obs, ex(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   localparam int NALU = 4;
   logic [2:0] alu_f3  [NALU] = '{3'b111, 3'b110, 3'b010, 3'b000};
   logic       alu_f7  [NALU] = '{1'b0, 1'b0, 1'b0, 1'b0};
   logic [2:0] alu_exp [NALU] = '{3'b010, 3'b011, 3'b101, 3'b000};

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      op        = 7'b0000000;
      funct3    = 3'b000;
      funct7b5  = 1'b0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("por_outputs", obs, ex(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
`ifdef MC_CTRL_ILLEGAL_EN
      chk("por_illegal", {17'b0, illegal}, 18'b0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // lw, zero wait: 5 cycles
      op = 7'b0000011;
      push_fetch("lw", 0);
      push("lw_memadr",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
      push("lw_memread", 1'b1, 1'b0, ex(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      push("lw_memwb",   1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b000,1));
      drain();

      // sw with three wait cycles in MEMWRITE
      op = 7'b0100011;
      push_fetch("sw", 0);
      push("sw_memadr", 1'b0, 1'b0, ex(0,0,0,0,0,0,2'b01,2'b10,2'b01,2'b00,3'b000,0));
      for (int i = 0; i < 3; i++)
         push("sw_memwrite_wait", 1'b0, 1'b0, ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      push("sw_memwrite_done", 1'b1, 1'b0, ex(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
      drain();

      // R-type sub after two fetch wait cycles
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      push_fetch("rsub", 2);
      push("rsub_exec",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
      push("rsub_aluwb", 1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1));
      drain();

      // I-type with the same fields adds
      op = 7'b0010011;
      push_fetch("iadd", 0);
      push("iadd_exec",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
      push("iadd_aluwb", 1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1));
      drain();

      // R-type funct3 table
      op = 7'b0110011;
      for (int k = 0; k < NALU; k++) begin
         funct3 = alu_f3[k]; funct7b5 = alu_f7[k];
         push_fetch("rtab", 0);
         push("rtab_exec",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,alu_exp[k],0));
         push("rtab_aluwb", 1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1));
         drain();
      end

      // beq taken then not taken; mem_ready/zero held high where they must be ignored
      op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
      push("beq1_fetch",  1'b1, 1'b1, ex(1,0,0,1,1,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
      push("beq1_decode", 1'b1, 1'b1, ex(0,0,0,0,0,0,2'b10,2'b01,2'b01,2'b00,3'b000,0));
      push("beq1_taken",  1'b1, 1'b1, ex(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,3'b001,1));
      push_fetch("beq0", 0);
      push("beq0_nottaken", 1'b1, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,1));
      drain();

      // reset mid-MEMREAD with mem_ready low
      op = 7'b0000011;
      push_fetch("lwrst", 0);
      push("lwrst_memadr",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
      push("lwrst_memread", 1'b0, 1'b0, ex(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      drain();
      do_reset();
      op = 7'b0010011; funct3 = 3'b110;
      push_fetch("after_rst", 0);
      push("after_rst_exec",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0));
      push("after_rst_aluwb", 1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1));
      drain();

      // unknown opcode
      op = 7'b1111111;
      push_fetch("unk", 0);
`ifdef MC_CTRL_ILLEGAL_EN
      for (int i = 0; i < 3; i++)
         push("unk_illegal", 1'b1, 1'b1, ex(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      drain();
      chk("unk_illegal_flag", {17'b0, illegal}, 18'b1);
      do_reset();
      chk("unk_illegal_cleared", {17'b0, illegal}, 18'b0);
`else
      push("unk_nop_fetch", 1'b0, 1'b0, ex(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,3'b000,0));
      drain();
`endif
      op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
      push_fetch("final", 0);
      push("final_exec",  1'b0, 1'b0, ex(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
      push("final_aluwb", 1'b0, 1'b0, ex(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
